ram_pipelined_bytelane: RTL and testbench

//  Dual-port unified instruction/data RAM for the core, with a registered read pipeline,

---
 rtl/ram_pipelined_bytelane_pkg.sv | 43 ++++
 rtl/ram_pipelined_bytelane_load_align.sv | 42 ++++
 rtl/ram_pipelined_bytelane.sv | 145 ++++++++++++++
 tb/tb_ram_pipelined_bytelane.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pipelined_bytelane_pkg.sv
// Shared encodings and lane helpers for the pipelined byte-lane RAM.
// Access sizes follow the RISC-V load/store width field.
package ram_pipelined_bytelane_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    localparam int LANES     = 4;
    localparam int LANE_BITS = 2;

    function automatic int lanes_for(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int lane_bits_for(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // Byte lanes touched by an access of the given size, before shifting to the address.
    function automatic logic [7:0] size_lane_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0f;
            default: return 8'hff;
        endcase
    endfunction

    // Address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_addr_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/ram_pipelined_bytelane_load_align.sv
// Load result formatting: moves the addressed lanes down to bit 0 and
// sign- or zero-extends them to the full word.
module ram_load_align
    import ram_pipelined_bytelane_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LANE_BITS_P = 2
) (
    input  logic [DATA_WIDTH-1:0]  word,
    input  logic [LANE_BITS_P-1:0] lane,
    input  logic [1:0]             size,
    input  logic                   is_unsigned,
    output logic [DATA_WIDTH-1:0]  data
);

    localparam int IDXW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] keep;
    logic [IDXW-1:0]       msb_idx;
    logic                  sign;
    int                    nbits;

    always_comb begin
        shifted = word >> {lane, 3'b000};
        case (size)
            SZ_B:    nbits = 8;
            SZ_H:    nbits = 16;
            SZ_W:    nbits = 32;
            default: nbits = 64;
        endcase
        if (nbits > DATA_WIDTH) begin
            nbits = DATA_WIDTH;
        end
        msb_idx = IDXW'(nbits - 1);
        sign    = ~is_unsigned & shifted[msb_idx];
        // A shift by the full width yields zero, so keep covers every bit for full-word loads.
        keep    = ~({DATA_WIDTH{1'b1}} << nbits);
        data    = (shifted & keep) | (~keep & {DATA_WIDTH{sign}});
    end

endmodule

// File: rtl/ram_pipelined_bytelane.sv
// Dual-port instruction/data RAM with byte-lane stores, sub-word loads and a
// configurable-depth registered response pipeline.
module ram_pipelined_bytelane
    import ram_pipelined_bytelane_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = ""
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic                  i_valid,
    output logic [DATA_WIDTH-1:0] i_read_data,
    input  logic                  d_req,
    input  logic                  d_wEn,
    input  logic [1:0]            d_size,
    input  logic                  d_unsigned,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [DATA_WIDTH-1:0] d_write_data,
    output logic                  d_valid,
    output logic [DATA_WIDTH-1:0] d_read_data,
    output logic                  d_misaligned
);

    localparam int NLANES = lanes_for(DATA_WIDTH);
    localparam int LB     = lane_bits_for(DATA_WIDTH);
    localparam int IW     = ADDR_WIDTH - LB;
    localparam int DEPTH  = 1 << IW;

    typedef struct packed {
        logic                  vld;
        logic                  wen;
        logic                  mis;
        logic                  uns;
        logic [1:0]            size;
        logic [LB-1:0]         lane;
        logic [DATA_WIDTH-1:0] word;
    } d_stage_t;

    typedef struct packed {
        logic                  vld;
        logic [DATA_WIDTH-1:0] word;
    } i_stage_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    d_stage_t d_pipe_d [READ_LATENCY];
    d_stage_t d_pipe_q [READ_LATENCY];
    i_stage_t i_pipe_d [READ_LATENCY];
    i_stage_t i_pipe_q [READ_LATENCY];

    logic [IW-1:0]         d_idx;
    logic [IW-1:0]         i_idx;
    logic [LB-1:0]         d_lane;
    logic                  d_mis;
    logic                  wr_en;
    logic [15:0]           be_wide;
    logic [NLANES-1:0]     be;
    logic [DATA_WIDTH-1:0] wdata_sh;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  unused_i_lane;

    assign unused_i_lane = ^i_address[LB-1:0];

    always_comb begin
        d_idx    = d_address[ADDR_WIDTH-1:LB];
        i_idx    = i_address[ADDR_WIDTH-1:LB];
        d_lane   = d_address[LB-1:0];
        d_mis    = ((d_size == SZ_D) && (DATA_WIDTH == 32)) ||
                   ((d_address[2:0] & size_addr_mask(d_size)) != 3'b000);
        wr_en    = d_req & d_wEn & ~d_mis & ~reset;
        be_wide  = {8'h00, size_lane_mask(d_size)} << d_lane;
        be       = be_wide[NLANES-1:0];
        wdata_sh = d_write_data << {d_lane, 3'b000};
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int l = 0; l < NLANES; l++) begin
                if (be[l]) begin
                    mem[d_idx][8*l +: 8] <= wdata_sh[8*l +: 8];
                end
            end
        end
    end

    // Stage 0 captures the array word combinationally; registering it at the
    // request edge gives read-first behaviour against a same-edge store.
    always_comb begin
        d_pipe_d[0].vld  = d_req;
        d_pipe_d[0].wen  = d_wEn;
        d_pipe_d[0].mis  = d_mis;
        d_pipe_d[0].uns  = d_unsigned;
        d_pipe_d[0].size = d_size;
        d_pipe_d[0].lane = d_lane;
        d_pipe_d[0].word = mem[d_idx];
        i_pipe_d[0].vld  = i_req;
        i_pipe_d[0].word = mem[i_idx];
        for (int k = 1; k < READ_LATENCY; k++) begin
            d_pipe_d[k] = d_pipe_q[k-1];
            i_pipe_d[k] = i_pipe_q[k-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                d_pipe_q[k] <= '0;
                i_pipe_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                d_pipe_q[k] <= d_pipe_d[k];
                i_pipe_q[k] <= i_pipe_d[k];
            end
        end
    end

    ram_load_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_BITS_P(LB)
    ) u_load_align (
        .word       (d_pipe_q[READ_LATENCY-1].word),
        .lane       (d_pipe_q[READ_LATENCY-1].lane),
        .size       (d_pipe_q[READ_LATENCY-1].size),
        .is_unsigned(d_pipe_q[READ_LATENCY-1].uns),
        .data       (load_data)
    );

    always_comb begin
        d_valid      = d_pipe_q[READ_LATENCY-1].vld;
        d_misaligned = d_pipe_q[READ_LATENCY-1].vld & d_pipe_q[READ_LATENCY-1].mis;
        d_read_data  = '0;
        if (d_pipe_q[READ_LATENCY-1].vld && !d_pipe_q[READ_LATENCY-1].wen &&
            !d_pipe_q[READ_LATENCY-1].mis) begin
            d_read_data = load_data;
        end
        i_valid     = i_pipe_q[READ_LATENCY-1].vld;
        i_read_data = i_pipe_q[READ_LATENCY-1].vld ? i_pipe_q[READ_LATENCY-1].word : '0;
    end

endmodule

// File: tb/tb_ram_pipelined_bytelane.sv
// Directed bench for ram_pipelined_bytelane: a latency-1 instance for the
// functional cases and a latency-3 instance for pipelining and reset drop.
module tb_ram_pipelined_bytelane;

    logic        clock;
    logic        reset;
    logic        i_req;
    logic [15:0] i_address;
    logic        i_valid;
    logic [31:0] i_read_data;
    logic        d_req;
    logic        d_wEn;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [15:0] d_address;
    logic [31:0] d_write_data;
    logic        d_valid;
    logic [31:0] d_read_data;
    logic        d_misaligned;

    logic        l3_reset;
    logic        l3_i_valid;
    logic [31:0] l3_i_read_data;
    logic        l3_d_req;
    logic        l3_d_wEn;
    logic [1:0]  l3_d_size;
    logic [15:0] l3_d_address;
    logic [31:0] l3_d_write_data;
    logic        l3_d_valid;
    logic [31:0] l3_d_read_data;
    logic        l3_d_misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    ram_pipelined_bytelane #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .READ_LATENCY(1)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .i_req       (i_req),
        .i_address   (i_address),
        .i_valid     (i_valid),
        .i_read_data (i_read_data),
        .d_req       (d_req),
        .d_wEn       (d_wEn),
        .d_size      (d_size),
        .d_unsigned  (d_unsigned),
        .d_address   (d_address),
        .d_write_data(d_write_data),
        .d_valid     (d_valid),
        .d_read_data (d_read_data),
        .d_misaligned(d_misaligned)
    );

    ram_pipelined_bytelane #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .READ_LATENCY(3)) u_dut_l3 (
        .clock       (clock),
        .reset       (l3_reset),
        .i_req       (1'b0),
        .i_address   (16'h0000),
        .i_valid     (l3_i_valid),
        .i_read_data (l3_i_read_data),
        .d_req       (l3_d_req),
        .d_wEn       (l3_d_wEn),
        .d_size      (l3_d_size),
        .d_unsigned  (1'b0),
        .d_address   (l3_d_address),
        .d_write_data(l3_d_write_data),
        .d_valid     (l3_d_valid),
        .d_read_data (l3_d_read_data),
        .d_misaligned(l3_d_misaligned)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic ir, input logic [15:0] ia, input logic dr, input logic we,
                        input logic [1:0] sz, input logic un, input logic [15:0] da,
                        input logic [31:0] wd);
        i_req        = ir;
        i_address    = ia;
        d_req        = dr;
        d_wEn        = we;
        d_size       = sz;
        d_unsigned   = un;
        d_address    = da;
        d_write_data = wd;
        @(posedge clock);
        #1;
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic store(input string tag, input logic [1:0] sz, input logic [15:0] da,
                         input logic [31:0] wd);
        step(1'b0, 16'h0, 1'b1, 1'b1, sz, 1'b0, da, wd);
        check_eq({tag, "_valid"}, d_valid, 1'b1);
        check_eq({tag, "_mis"}, d_misaligned, 1'b0);
        check_eq({tag, "_data"}, d_read_data, 32'h0);
    endtask

    task automatic load(input string tag, input logic [1:0] sz, input logic un,
                        input logic [15:0] da, input logic [31:0] exp);
        step(1'b0, 16'h0, 1'b1, 1'b0, sz, un, da, 32'h0);
        check_eq({tag, "_valid"}, d_valid, 1'b1);
        check_eq({tag, "_mis"}, d_misaligned, 1'b0);
        check_eq({tag, "_data"}, d_read_data, exp);
    endtask

    task automatic l3_drive(input logic dr, input logic we, input logic [15:0] da,
                            input logic [31:0] wd);
        l3_d_req        = dr;
        l3_d_wEn        = we;
        l3_d_size       = 2'd2;
        l3_d_address    = da;
        l3_d_write_data = wd;
    endtask

    initial begin
        logic exp_v;
        reset = 1'b1;
        l3_reset = 1'b1;
        i_req = 1'b0; i_address = '0; d_req = 1'b0; d_wEn = 1'b0; d_size = '0;
        d_unsigned = 1'b0; d_address = '0; d_write_data = '0;
        l3_drive(1'b0, 1'b0, 16'h0, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        l3_reset = 1'b0;

        // Reset with live requests: nothing written, nothing returned.
        store("pre_sw40", 2'd2, 16'h0040, 32'h1357_2468);
        reset = 1'b1;
        i_req = 1'b1; i_address = 16'h0040;
        d_req = 1'b1; d_wEn = 1'b1; d_size = 2'd2; d_address = 16'h0040;
        d_write_data = 32'hCAFE_F00D;
        for (int c = 0; c < 2; c++) begin
            @(posedge clock);
            #1;
            check_eq($sformatf("rst_dvalid_%0d", c), d_valid, 1'b0);
            check_eq($sformatf("rst_ivalid_%0d", c), i_valid, 1'b0);
            check_eq($sformatf("rst_dmis_%0d", c), d_misaligned, 1'b0);
            check_eq($sformatf("rst_ddata_%0d", c), d_read_data, 32'h0);
            check_eq($sformatf("rst_idata_%0d", c), i_read_data, 32'h0);
        end
        reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clock);
            #1;
            check_eq($sformatf("post_rst_dvalid_%0d", c), d_valid, 1'b0);
            check_eq($sformatf("post_rst_ivalid_%0d", c), i_valid, 1'b0);
        end
        load("rst_no_write", 2'd2, 1'b0, 16'h0040, 32'h1357_2468);

        // Sub-word loads from a freshly stored word.
        store("sw10", 2'd2, 16'h0010, 32'hDEAD_BEEF);
        load("lb13", 2'd0, 1'b0, 16'h0013, 32'hFFFF_FFDE);
        load("lbu13", 2'd0, 1'b1, 16'h0013, 32'h0000_00DE);
        load("lh12", 2'd1, 1'b0, 16'h0012, 32'hFFFF_DEAD);
        load("lw10", 2'd2, 1'b0, 16'h0010, 32'hDEAD_BEEF);
        load("lhu10", 2'd1, 1'b1, 16'h0010, 32'h0000_BEEF);
        load("lb10", 2'd0, 1'b0, 16'h0010, 32'hFFFF_FFEF);
        load("lh10", 2'd1, 1'b0, 16'h0010, 32'hFFFF_BEEF);

        // Byte store merges into one lane only; neighbours untouched.
        store("sw14", 2'd2, 16'h0014, 32'h1111_1111);
        store("sw0c", 2'd2, 16'h000C, 32'h2222_2222);
        store("sb11", 2'd0, 16'h0011, 32'hFFFF_FF5A);
        load("lw10_sb", 2'd2, 1'b0, 16'h0010, 32'hDEAD_5AEF);
        load("lw14", 2'd2, 1'b0, 16'h0014, 32'h1111_1111);
        load("lw0c", 2'd2, 1'b0, 16'h000C, 32'h2222_2222);
        store("sh16", 2'd1, 16'h0016, 32'hFFFF_8001);
        load("lw14_sh", 2'd2, 1'b0, 16'h0014, 32'h8001_1111);

        // Misaligned accesses are flagged and suppressed.
        step(1'b0, 16'h0, 1'b1, 1'b1, 2'd1, 1'b0, 16'h0011, 32'h0000_7777);
        check_eq("sh11_valid", d_valid, 1'b1);
        check_eq("sh11_mis", d_misaligned, 1'b1);
        check_eq("sh11_data", d_read_data, 32'h0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 2'd2, 1'b0, 16'h0012, 32'h0);
        check_eq("lw12_valid", d_valid, 1'b1);
        check_eq("lw12_mis", d_misaligned, 1'b1);
        check_eq("lw12_data", d_read_data, 32'h0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 2'd3, 1'b0, 16'h0010, 32'h0);
        check_eq("ld10_mis", d_misaligned, 1'b1);
        check_eq("ld10_data", d_read_data, 32'h0);
        step(1'b0, 16'h0, 1'b1, 1'b1, 2'd3, 1'b0, 16'h0010, 32'h0BAD_0BAD);
        check_eq("sd10_mis", d_misaligned, 1'b1);
        load("lw10_after_mis", 2'd2, 1'b0, 16'h0010, 32'hDEAD_5AEF);

        // Same-edge fetch and store to one word: fetch sees the old contents.
        store("sw20_old", 2'd2, 16'h0020, 32'hA5A5_A5A5);
        step(1'b1, 16'h0020, 1'b1, 1'b1, 2'd2, 1'b0, 16'h0020, 32'h0000_1234);
        check_eq("fetch20_valid", i_valid, 1'b1);
        check_eq("fetch20_old", i_read_data, 32'hA5A5_A5A5);
        check_eq("sw20_valid", d_valid, 1'b1);
        step(1'b1, 16'h0022, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 32'h0);
        check_eq("fetch22_valid", i_valid, 1'b1);
        check_eq("fetch22_new", i_read_data, 32'h0000_1234);
        step(1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 32'h0);
        check_eq("idle_ivalid", i_valid, 1'b0);
        check_eq("idle_dvalid", d_valid, 1'b0);

        // Latency-3 instance: preload eight words.
        for (int k = 0; k < 8; k++) begin
            l3_drive(1'b1, 1'b1, 16'h0100 + 16'(4 * k), 32'h1000 + 32'(k));
            @(posedge clock);
            #1;
        end
        l3_drive(1'b0, 1'b0, 16'h0, 32'h0);
        repeat (4) @(posedge clock);
        #1;

        for (int j = 0; j < 12; j++) begin
            if (j < 8) l3_drive(1'b1, 1'b0, 16'h0100 + 16'(4 * j), 32'h0);
            else       l3_drive(1'b0, 1'b0, 16'h0, 32'h0);
            @(posedge clock);
            #1;
            exp_v = (j >= 2) && (j < 10);
            check_eq($sformatf("l3_valid_%0d", j), l3_d_valid, exp_v);
            if (exp_v) check_eq($sformatf("l3_data_%0d", j), l3_d_read_data, 32'h1000 + 32'(j - 2));
        end

        // Reset at cycle 5 drops everything still in flight.
        for (int j = 0; j < 12; j++) begin
            l3_reset = (j == 5);
            if (j < 5) l3_drive(1'b1, 1'b0, 16'h0100 + 16'(4 * j), 32'h0);
            else       l3_drive(1'b0, 1'b0, 16'h0, 32'h0);
            @(posedge clock);
            #1;
            exp_v = (j >= 2) && (j < 5);
            check_eq($sformatf("l3_rst_valid_%0d", j), l3_d_valid, exp_v);
            if (exp_v) check_eq($sformatf("l3_rst_data_%0d", j), l3_d_read_data, 32'h1000 + 32'(j - 2));
        end
        l3_reset = 1'b0;
        check_eq("l3_rst_mis", l3_d_misaligned, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
